// File: rtl/tow_match_if.sv
// Signal bundle between the tug-of-war match controller and its surroundings
// (button/edge inputs, move/clear outputs, score and status).
interface tow_match_if #(
   parameter int SCORE_W = 3
);
   logic               start;
   logic               pressL;
   logic               pressR;
   logic               edgeL;
   logic               edgeR;
   logic               moveL;
   logic               moveR;
   logic               fieldReset;
   logic [SCORE_W-1:0] scoreL;
   logic [SCORE_W-1:0] scoreR;
   logic               matchDone;
   logic               winner;
   logic [2:0]         state;

   modport slave (
      input  start, pressL, pressR, edgeL, edgeR,
      output moveL, moveR, fieldReset, scoreL, scoreR, matchDone, winner, state
   );

   modport master (
      output start, pressL, pressR, edgeL, edgeR,
      input  moveL, moveR, fieldReset, scoreL, scoreR, matchDone, winner, state
   );
endinterface

// File: rtl/tow_match_controller.sv
// Best-of-N match sequencer for the tug-of-war light field with post-round lockout.
// Optional macro TOW_RR_ARB_EN: round-robin grant on simultaneous presses (else they cancel).
module tow_match_controller #(
   parameter int ROUNDS_TO_WIN  = 3,
   parameter int LOCKOUT_CYCLES = 8,
   parameter int SCORE_W        = 3
) (
   input  logic        Clock,
   input  logic        Reset,
   tow_match_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      CLEAR      = 3'd1,
      PLAY       = 3'd2,
      ROUND_WON  = 3'd3,
      MATCH_OVER = 3'd4
   } state_t;

   localparam int                 CNT_W     = $clog2(LOCKOUT_CYCLES + 1);
   localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(ROUNDS_TO_WIN);
   localparam logic [SCORE_W-1:0] ONE_S     = SCORE_W'(1);
   localparam logic [CNT_W-1:0]   LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES);
   localparam logic [CNT_W-1:0]   ONE_C     = CNT_W'(1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   lock_q, lock_d;
   logic [SCORE_W-1:0] scoreL_q, scoreL_d;
   logic [SCORE_W-1:0] scoreR_q, scoreR_d;
   logic               moveL_q, moveL_d;
   logic               moveR_q, moveR_d;
   logic               fieldReset_q, fieldReset_d;
   logic               matchDone_q, matchDone_d;
   logic               winner_q, winner_d;
`ifdef TOW_RR_ARB_EN
   logic               ptr_q, ptr_d;
`endif

   logic edge_hit, lock_done, match_won;

   assign edge_hit  = bus.edgeL | bus.edgeR;
   assign lock_done = (lock_q == ONE_C);
   assign match_won = (scoreL_q == WIN) || (scoreR_q == WIN);

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q      <= IDLE;
         lock_q       <= '0;
         scoreL_q     <= '0;
         scoreR_q     <= '0;
         moveL_q      <= 1'b0;
         moveR_q      <= 1'b0;
         fieldReset_q <= 1'b1;
         matchDone_q  <= 1'b0;
         winner_q     <= 1'b0;
`ifdef TOW_RR_ARB_EN
         ptr_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         lock_q       <= lock_d;
         scoreL_q     <= scoreL_d;
         scoreR_q     <= scoreR_d;
         moveL_q      <= moveL_d;
         moveR_q      <= moveR_d;
         fieldReset_q <= fieldReset_d;
         matchDone_q  <= matchDone_d;
         winner_q     <= winner_d;
`ifdef TOW_RR_ARB_EN
         ptr_q        <= ptr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (bus.start) state_d = CLEAR;
         CLEAR:      state_d = PLAY;
         PLAY:       if (edge_hit) state_d = ROUND_WON;
         ROUND_WON:  if (lock_done) state_d = match_won ? MATCH_OVER : CLEAR;
         MATCH_OVER: if (bus.start) state_d = CLEAR;
         default:    state_d = IDLE;
      endcase
   end

   // Registered outputs are computed from the upcoming state so they line up with state_q.
   always_comb begin
      moveL_d      = 1'b0;
      moveR_d      = 1'b0;
      lock_d       = lock_q;
      scoreL_d     = scoreL_q;
      scoreR_d     = scoreR_q;
      winner_d     = winner_q;
      fieldReset_d = (state_d == IDLE) || (state_d == CLEAR);
      matchDone_d  = (state_d == MATCH_OVER);
`ifdef TOW_RR_ARB_EN
      ptr_d        = ptr_q;
`endif
      case (state_q)
         IDLE, MATCH_OVER: begin
            if (bus.start) begin
               scoreL_d = '0;
               scoreR_d = '0;
            end
         end
         PLAY: begin
            if (edge_hit) begin
               lock_d = LOCK_LOAD;
               if (bus.edgeL) begin
                  if (scoreL_q != WIN) scoreL_d = scoreL_q + ONE_S;
               end else if (scoreR_q != WIN) begin
                  scoreR_d = scoreR_q + ONE_S;
               end
            end else if (bus.pressL && !bus.pressR) begin
               moveL_d = 1'b1;
            end else if (bus.pressR && !bus.pressL) begin
               moveR_d = 1'b1;
            end else if (bus.pressL && bus.pressR) begin
`ifdef TOW_RR_ARB_EN
               moveL_d = ~ptr_q;
               moveR_d = ptr_q;
               ptr_d   = ~ptr_q;
`else
               moveL_d = 1'b0;
               moveR_d = 1'b0;
`endif
            end
         end
         ROUND_WON: begin
            if (lock_q != '0) lock_d = lock_q - ONE_C;
            if (lock_done && match_won) winner_d = (scoreL_q != WIN);
         end
         default: ;
      endcase
   end

   assign bus.moveL      = moveL_q;
   assign bus.moveR      = moveR_q;
   assign bus.fieldReset = fieldReset_q;
   assign bus.scoreL     = scoreL_q;
   assign bus.scoreR     = scoreR_q;
   assign bus.matchDone  = matchDone_q;
   assign bus.winner     = winner_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_tow_match_controller.sv
// Directed bench for tow_match_controller with ROUNDS_TO_WIN=2, LOCKOUT_CYCLES=4.
module tb_tow_match_controller;

   logic Clock = 1'b0;
   logic Reset = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   tow_match_if #(.SCORE_W(3)) bus ();

   tow_match_controller #(
      .ROUNDS_TO_WIN (2),
      .LOCKOUT_CYCLES(4),
      .SCORE_W       (3)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start  = 1'b0;
      bus.pressL = 1'b0;
      bus.pressR = 1'b0;
      bus.edgeL  = 1'b0;
      bus.edgeR  = 1'b0;
   endtask

   // Expected grants for three consecutive ties: {moveL, moveR}
`ifdef TOW_RR_ARB_EN
   logic [1:0] tie_exp [3] = '{2'b10, 2'b01, 2'b10};
`else
   logic [1:0] tie_exp [3] = '{2'b00, 2'b00, 2'b00};
`endif

   initial begin
      int move_cnt;
      idle_inputs();

      // 1. reset, start, CLEAR for one cycle, PLAY
      tick();
      tick();
      chk("rst_state", bus.state, 0);
      chk("rst_fieldReset", bus.fieldReset, 1);
      chk("rst_scoreL", bus.scoreL, 0);
      chk("rst_scoreR", bus.scoreR, 0);
      chk("rst_moves", {bus.moveL, bus.moveR}, 0);
      chk("rst_matchDone", bus.matchDone, 0);
      Reset = 1'b1;
      tick();
      chk("idle_state", bus.state, 0);
      bus.start = 1'b1;
      tick();
      chk("clear_state", bus.state, 1);
      chk("clear_fieldReset", bus.fieldReset, 1);
      bus.start = 1'b0;
      bus.pressL = 1'b1;
      tick();
      chk("play_state", bus.state, 2);
      chk("play_fieldReset", bus.fieldReset, 0);
      chk("clear_press_ignored", bus.moveL, 0);
      bus.pressL = 1'b0;
      tick();

      // 2. single presses, latency 1, one-cycle pulses
      bus.pressR = 1'b1;
      tick();
      chk("moveR_n1", bus.moveR, 1);
      chk("moveL_quiet", bus.moveL, 0);
      bus.pressR = 1'b0;
      tick();
      chk("moveR_n2", bus.moveR, 0);
      move_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         bus.pressL = 1'b1;
         tick();
         move_cnt += int'(bus.moveL);
         chk("moveL_pulse", bus.moveL, 1);
         bus.pressL = 1'b0;
         for (int j = 0; j < 2; j++) begin
            tick();
            move_cnt += int'(bus.moveL);
         end
      end
      chk("moveL_count", move_cnt, 4);

      // 3. left round won, press in the same cycle dropped, 4-cycle lockout
      bus.edgeL  = 1'b1;
      bus.pressR = 1'b1;
      tick();
      chk("rw_state", bus.state, 3);
      chk("rw_moveR_dropped", bus.moveR, 0);
      chk("rw_scoreL", bus.scoreL, 1);
      chk("rw_fieldReset", bus.fieldReset, 0);
      bus.edgeL  = 1'b0;
      bus.pressR = 1'b0;
      bus.pressL = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rw_hold", bus.state, 3);
         chk("rw_press_ignored", bus.moveL, 0);
      end
      bus.pressL = 1'b0;
      tick();
      chk("rw_to_clear", bus.state, 1);
      chk("rw_clear_fieldReset", bus.fieldReset, 1);
      tick();
      chk("rw_to_play", bus.state, 2);

      // 4. second left round wins the match
      bus.edgeL = 1'b1;
      tick();
      chk("rw2_scoreL", bus.scoreL, 2);
      bus.edgeL = 1'b0;
      tick();
      tick();
      tick();
      chk("rw2_hold", bus.state, 3);
      tick();
      chk("mo_state", bus.state, 4);
      chk("mo_matchDone", bus.matchDone, 1);
      chk("mo_winner", bus.winner, 0);
      chk("mo_scoreL", bus.scoreL, 2);
      chk("mo_fieldReset", bus.fieldReset, 0);
      bus.pressL = 1'b1;
      bus.pressR = 1'b1;
      tick();
      chk("mo_moves_blocked", {bus.moveL, bus.moveR}, 0);
      chk("mo_stays", bus.state, 4);
      bus.pressL = 1'b0;
      bus.pressR = 1'b0;
      bus.start  = 1'b1;
      tick();
      chk("mo_restart_state", bus.state, 1);
      chk("mo_restart_scoreL", bus.scoreL, 0);
      chk("mo_restart_matchDone", bus.matchDone, 0);
      bus.start = 1'b0;
      tick();
      chk("restart_play", bus.state, 2);

      // 5. simultaneous presses
      for (int i = 0; i < 3; i++) begin
         bus.pressL = 1'b1;
         bus.pressR = 1'b1;
         tick();
         chk("tie_moves", {bus.moveL, bus.moveR}, int'(tie_exp[i]));
         bus.pressL = 1'b0;
         bus.pressR = 1'b0;
         tick();
         chk("tie_gap", {bus.moveL, bus.moveR}, 0);
      end

      // 6. reset in the middle of a lockout
      bus.edgeR = 1'b1;
      tick();
      chk("rwR_scoreR", bus.scoreR, 1);
      chk("rwR_scoreL", bus.scoreL, 0);
      bus.edgeR = 1'b0;
      tick();
      chk("rwR_hold", bus.state, 3);
      Reset = 1'b0;
      tick();
      chk("mid_rst_state", bus.state, 0);
      chk("mid_rst_scoreR", bus.scoreR, 0);
      chk("mid_rst_fieldReset", bus.fieldReset, 1);
      chk("mid_rst_counter", int'(dut.lock_q), 0);
      Reset = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("post_rst_play", bus.state, 2);

      // both edges lit: left has priority, lockout reloads to full length
      bus.edgeL = 1'b1;
      bus.edgeR = 1'b1;
      tick();
      chk("both_edges_scoreL", bus.scoreL, 1);
      chk("both_edges_scoreR", bus.scoreR, 0);
      idle_inputs();
      tick();
      tick();
      tick();
      chk("reload_hold", bus.state, 3);
      tick();
      chk("reload_expire", bus.state, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tow_match_controller.md
Name: tow_match_controller

Overview:
- Match sequencer for the tug-of-war light field (nine-light chain plus center light).
- Inputs: debounced one-cycle press pulses from the two player buttons, and the two end-light states.
- Outputs: arbitrated move pulses and a field clear to the light chain.
- Keeps per-player round scores and runs a best-of-N match with a post-round lockout, so the field is cleared and restarted automatically between rounds.

Parameters:
- ROUNDS_TO_WIN, 3, rounds a player must win to take the match; must be < 2**SCORE_W.
- LOCKOUT_CYCLES, 8, number of cycles the ROUND_WON state lasts, with inputs ignored; must be ≥ 1.
- SCORE_W, 3, width of each score counter.

Ports:
- Clock  in  1  system clock (CLOCK_50 domain)
- Reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a match from IDLE or MATCH_OVER
- pressL  in  1  one-cycle left-player press pulse (KEY[3] button path)
- pressR  in  1  one-cycle right-player press pulse (KEY[0] button path)
- edgeL  in  1  leftmost light lit (LEDR[9])
- edgeR  in  1  rightmost light lit (LEDR[1])
- moveL  out  1  one-cycle pulse to the light chain L input
- moveR  out  1  one-cycle pulse to the light chain R input
- fieldReset  out  1  drives the light chain reset; center light on, others off
- scoreL  out  SCORE_W  left rounds won
- scoreR  out  SCORE_W  right rounds won
- matchDone  out  1  high while in MATCH_OVER
- winner  out  1  0 = left, 1 = right; valid only when matchDone is 1
- state  out  3  IDLE=0, CLEAR=1, PLAY=2, ROUND_WON=3, MATCH_OVER=4

Behaviour:
- All outputs are registered and all logic is sampled on posedge Clock.

Reset:
- Reset==0 at a posedge forces: state=IDLE, scores=0, moveL=moveR=0, fieldReset=1, matchDone=0, winner=0, lockout counter=0, arbitration pointer=left.
- Reset overrides every state, including mid-round and mid-lockout.

IDLE:
- fieldReset=1; moves are blocked.
- start=1 -> CLEAR; scores are cleared.

CLEAR:
- Lasts exactly 1 cycle with fieldReset=1.
- Presses are ignored.
- Always -> PLAY.

PLAY:
- fieldReset=0.
- A press accepted in cycle N produces moveL or moveR high in cycle N+1 only (latency 1).
- pressL alone -> moveL. pressR alone -> moveR.
- Both presses in the same cycle -> see Optional Feature.
- edgeL=1 or edgeR=1 -> ROUND_WON. Any press in that same cycle is dropped.
- On that transition, the matching score increments by 1. If both edges are high (illegal field state), left takes priority.
- start is ignored.

ROUND_WON:
- Moves are blocked; fieldReset=0, so the winning end light stays visible.
- The counter runs LOCKOUT_CYCLES cycles.
- On expiry, if either score == ROUNDS_TO_WIN -> MATCH_OVER; otherwise -> CLEAR.
- Presses and start are ignored.

MATCH_OVER:
- matchDone=1; winner is latched on entry.
- Scores are held; fieldReset=0.
- start=1 -> scores cleared, matchDone=0 -> CLEAR.

Width and boundary rules:
- Scores never exceed ROUNDS_TO_WIN.
- Score compare is equality at full SCORE_W width.
- Lockout counter width is $clog2(LOCKOUT_CYCLES+1); it reloads on every entry to ROUND_WON.
- A press landing in the cycle of any state transition out of PLAY is discarded, never queued.
- moveL and moveR are never high together.

Optional Feature:
- Macro: TOW_RR_ARB_EN.
- Defined: a simultaneous pressL and pressR in PLAY grants one move via round-robin.
  - The grant goes to the player not granted on the previous tie; the first tie after reset goes to left.
  - The pointer flips only on ties.
- Undefined: simultaneous presses cancel; neither move pulse is issued. No pointer register is built.

Test Plan:
Bench parameters: ROUNDS_TO_WIN=2, LOCKOUT_CYCLES=4.
1. Reset=0 for 2 cycles, then 1 -> state=0, fieldReset=1, scores=0, no moves. Start pulse -> state=1 for exactly 1 cycle, then state=2 with fieldReset=0.
2. In PLAY, pressR pulse at cycle N -> moveR=1 at N+1 only. Four pressL pulses spaced 3 cycles apart -> exactly four moveL pulses.
3. Hold edgeL=1 in PLAY with a pressR in the same cycle -> no moveR; scoreL=1; state=3 for 4 cycles, then CLEAR (fieldReset=1 for 1 cycle), then PLAY.
4. Win a second left round -> after lockout, state=4, matchDone=1, winner=0, scoreL=2. Presses ignored. Start -> scores 0, CLEAR.
5. Simultaneous pressL and pressR in PLAY:
   - macro undefined -> no move;
   - macro defined -> moveL on first tie, moveR on second tie, moveL on third tie.
6. Assert Reset=0 mid-ROUND_WON with scoreR=1 -> next cycle state=0, scores=0, fieldReset=1, counter cleared.
